// File: rtl/sv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : sv_seq
//  Purpose  : Microcode sequencer. Fetches 16-bit words and resolves jumps and
//             end words locally. Issues datapath ops over valid/ready.
//             Optional: SEQ_WDOG_EN adds a fetch-count watchdog.
//  Revision : 1.0 - initial release
// ============================================================================
module sv_seq #(
    parameter int ADDR_W   = 8,
    parameter int IM_DEPTH = 128,
    parameter int WDOG_MAX = 4096
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] iaddr_o,
    input  logic [15:0]       instr_i,
    output logic              op_valid_o,
    output logic [15:0]       op_o,
    input  logic              op_ready_i,
    input  logic              op_done_i,
    input  logic              flag_i
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_ISSUE  = 3'd3,
        S_WAIT   = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IM_DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH     = (ADDR_W + 1)'(IM_DEPTH);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              flag;

    logic              is_op;
    logic              is_jump;
    logic              is_end;
    logic              taken;
    logic [ADDR_W-1:0] target;
    logic              target_bad;
    logic              pc_last;

    assign is_op      = ~instr_i[0];
    assign is_jump    = (instr_i[1:0] == 2'b01);
    assign is_end     = (instr_i[1:0] == 2'b11) && (instr_i[15:2] == 14'd0);
    assign target     = instr_i[ADDR_W+3:4];
    assign taken      = (instr_i[3:2] == 2'b11)
                      | ((instr_i[3:2] == 2'b01) &  flag)
                      | ((instr_i[3:2] == 2'b10) & ~flag);
    assign target_bad = ({1'b0, target} >= DEPTH);
    assign pc_last    = (pc == LAST_ADDR);
    assign iaddr_o    = pc;

`ifdef SEQ_WDOG_EN
    localparam int               WDOG_W     = $clog2(WDOG_MAX + 1);
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(WDOG_MAX);
    logic [WDOG_W-1:0] fetch_cnt;
`endif

    // Outputs are set on the transition into the state that owns them, so
    // done_o/err_o/op_valid_o line up with their state and busy_o trails by one.
    always_ff @(posedge clk) begin
        if (areset) begin
            state      <= S_IDLE;
            pc         <= '0;
            flag       <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            op_valid_o <= 1'b0;
            op_o       <= '0;
`ifdef SEQ_WDOG_EN
            fetch_cnt  <= '0;
`endif
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        state  <= S_FETCH;
                        pc     <= '0;
                        flag   <= 1'b0;
                        busy_o <= 1'b1;
                        err_o  <= 1'b0;
`ifdef SEQ_WDOG_EN
                        fetch_cnt <= '0;
`endif
                    end
                end
                S_FETCH: begin
`ifdef SEQ_WDOG_EN
                    if (fetch_cnt == WDOG_LIMIT) begin
                        state <= S_ERR;
                        err_o <= 1'b1;
                    end else begin
                        fetch_cnt <= fetch_cnt + WDOG_W'(1);
                        state     <= S_DECODE;
                    end
`else
                    state <= S_DECODE;
`endif
                end
                S_DECODE: begin
                    if (is_op) begin
                        state      <= S_ISSUE;
                        op_o       <= instr_i;
                        op_valid_o <= 1'b1;
                    end else if (is_jump && taken) begin
                        if (target_bad) begin
                            state <= S_ERR;
                            err_o <= 1'b1;
                        end else begin
                            state <= S_FETCH;
                            pc    <= target;
                        end
                    end else if (is_jump) begin
                        if (pc_last) begin
                            state <= S_ERR;
                            err_o <= 1'b1;
                        end else begin
                            state <= S_FETCH;
                            pc    <= pc + ADDR_W'(1);
                        end
                    end else if (is_end) begin
                        state  <= S_DONE;
                        done_o <= 1'b1;
                    end else begin
                        state <= S_ERR;
                        err_o <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (op_ready_i) begin
                        op_valid_o <= 1'b0;
                        state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (op_done_i) begin
                        flag <= flag_i;
                        if (pc_last) begin
                            state <= S_ERR;
                            err_o <= 1'b1;
                        end else begin
                            state <= S_FETCH;
                            pc    <= pc + ADDR_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
                S_ERR: begin
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sv_seq
//  Purpose  : Self-checking bench for sv_seq with registered-read memory model,
//             datapath responder and an expected-op scoreboard queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sv_seq;

    logic        clk = 1'b0;
    logic        areset;
    logic        start_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [7:0]  iaddr_o;
    logic [15:0] instr_i;
    logic        op_valid_o;
    logic [15:0] op_o;
    logic        op_ready_i;
    logic        op_done_i;
    logic        flag_i;

    logic [15:0] mem [0:255];
    logic [7:0]  trace [0:1023];
    logic [15:0] sb [$];
    logic [15:0] held_op;

    int n_checks = 0;
    int n_fail   = 0;
    int n_accept = 0;
    int dp_ready_wait = 0;
    int dp_done_wait  = 1;
    logic dp_flag = 1'b0;
    int cyc;
    int acc0;

    sv_seq #(
        .ADDR_W  (8),
        .IM_DEPTH(128),
        .WDOG_MAX(16)
    ) dut (
        .clk       (clk),
        .areset    (areset),
        .start_i   (start_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .iaddr_o   (iaddr_o),
        .instr_i   (instr_i),
        .op_valid_o(op_valid_o),
        .op_o      (op_o),
        .op_ready_i(op_ready_i),
        .op_done_i (op_done_i),
        .flag_i    (flag_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) instr_i <= mem[iaddr_o];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Datapath responder: optional ready stall, then op_done after dp_done_wait cycles.
    initial begin : g_datapath
        op_ready_i = 1'b0;
        op_done_i  = 1'b0;
        flag_i     = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (op_valid_o && !areset) begin
                held_op = op_o;
                for (int i = 0; i < dp_ready_wait; i++) begin
                    @(posedge clk); #1;
                    check("hold_valid", op_valid_o, 1);
                    check("hold_op", op_o, held_op);
                end
                op_ready_i = 1'b1;
                @(posedge clk); #1;
                op_ready_i = 1'b0;
                n_accept++;
                if (sb.size() == 0) check("unexpected_op", sb.size(), 1);
                else                check("op_word", held_op, sb.pop_front());
                check("valid_drop", op_valid_o, 0);
                for (int i = 1; i < dp_done_wait; i++) begin
                    @(posedge clk); #1;
                end
                op_done_i = 1'b1;
                flag_i    = dp_flag;
                @(posedge clk); #1;
                op_done_i = 1'b0;
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'hFFFF;
    endtask

    task automatic run_prog(input int budget, input int mid_start, output int c);
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        check("busy_t1", busy_o, 1);
        check("iaddr_t1", iaddr_o, 0);
        check("err_cleared", err_o, 0);
        c = 0;
        trace[0] = iaddr_o;
        while (!done_o && !err_o && c < budget) begin
            start_i = (c == mid_start);
            @(posedge clk); #1;
            c++;
            trace[c] = iaddr_o;
        end
        start_i = 1'b0;
    endtask

    task automatic end_check(input logic exp_done, input logic exp_err);
        check("done", done_o, exp_done);
        check("err", err_o, exp_err);
        check("sb_drained", sb.size(), 0);
        @(posedge clk); #1;
        check("busy_fall", busy_o, 0);
        check("done_pulse", done_o, 0);
        check("err_sticky", err_o, exp_err);
    endtask

    initial begin : g_main
        #500000;
        $display("FAIL global_timeout at t=%0t", $time);
        $fatal(1);
    end

    initial begin
        areset  = 1'b1;
        start_i = 1'b0;
        clear_mem();
        repeat (3) @(posedge clk);
        #1;
        areset = 1'b0;
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        check("rst_valid", op_valid_o, 0);
        check("rst_iaddr", iaddr_o, 0);
        check("rst_op", op_o, 0);

        // Single op then end
        clear_mem();
        mem[0] = 16'h7804; mem[1] = 16'h0003;
        dp_ready_wait = 0; dp_done_wait = 3; dp_flag = 1'b0;
        sb.push_back(16'h7804);
        acc0 = n_accept;
        run_prog(200, -1, cyc);
        check("t1_cycles", cyc, 8);
        check("t1_iaddr_c2", trace[2], 8'h00);
        check("t1_iaddr_c6", trace[6], 8'h01);
        check("t1_accepts", n_accept - acc0, 1);
        end_check(1'b1, 1'b0);

        // Conditional jump taken / not taken
        for (int f = 0; f < 2; f++) begin
            clear_mem();
            mem[0] = 16'h005D; mem[5] = 16'hC000; mem[6] = 16'h0475;
            mem[8'h47] = 16'h0003; mem[7] = 16'h0003;
            dp_ready_wait = 0; dp_done_wait = 1; dp_flag = (f == 0);
            sb.push_back(16'hC000);
            run_prog(200, -1, cyc);
            check(f == 0 ? "cj_taken_addr" : "cj_fall_addr", iaddr_o, f == 0 ? 8'h47 : 8'h07);
            end_check(1'b1, 1'b0);
        end

        // Unconditional jumps, no datapath traffic
        clear_mem();
        mem[0] = 16'h009D; mem[9] = 16'h005D; mem[5] = 16'h0003;
        acc0 = n_accept;
        run_prog(200, -1, cyc);
        check("uj_cycles", cyc, 6);
        check("uj_fetch9", trace[2], 8'h09);
        check("uj_fetch5", trace[4], 8'h05);
        check("uj_no_ops", n_accept - acc0, 0);
        end_check(1'b1, 1'b0);

        // Nop, two ops under backpressure, jump-if-flag-0, start while busy
        clear_mem();
        mem[0] = 16'h0001; mem[1] = 16'h1234; mem[2] = 16'hABC2;
        mem[3] = 16'h0109; mem[8'h10] = 16'h0003;
        dp_ready_wait = 5; dp_done_wait = 2; dp_flag = 1'b0;
        sb.push_back(16'h1234);
        sb.push_back(16'hABC2);
        acc0 = n_accept;
        run_prog(300, 4, cyc);
        check("bp_accepts", n_accept - acc0, 2);
        check("bp_end_addr", iaddr_o, 8'h10);
        end_check(1'b1, 1'b0);

        // Illegal word
        clear_mem();
        mem[0] = 16'h0013;
        run_prog(50, -1, cyc);
        check("ill_cycles", cyc, 2);
        end_check(1'b0, 1'b1);

        // Jump beyond populated memory
        clear_mem();
        mem[0] = 16'h0FFD;
        run_prog(50, -1, cyc);
        check("jmp_oob_cycles", cyc, 2);
        end_check(1'b0, 1'b1);

        // Jump to last address is legal, incrementing past it is not
        clear_mem();
        mem[0] = 16'h07FD; mem[127] = 16'h0001;
        run_prog(50, -1, cyc);
        check("last_cycles", cyc, 4);
        check("last_no_wrap", iaddr_o, 8'd127);
        end_check(1'b0, 1'b1);

        // Runaway loop
        clear_mem();
        mem[0] = 16'h000D;
`ifdef SEQ_WDOG_EN
        run_prog(100, -1, cyc);
        check("wdog_cycles", cyc, 33);
        end_check(1'b0, 1'b1);
`else
        run_prog(1000, -1, cyc);
        check("loop_cycles", cyc, 1000);
        check("loop_busy", busy_o, 1);
        check("loop_err", err_o, 0);
`endif
        areset = 1'b1;
        @(posedge clk); #1;
        areset = 1'b0;
        check("midrst_busy", busy_o, 0);
        check("midrst_op", op_o, 0);
        check("midrst_err", err_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
